hazard_ctrl: RTL and testbench

Hazard and stall/flush generator for the 5-stage MIPS pipeline; produces stallF..stallW, flushE and the forwarding selects consumed by the controller and datapath. Detects load-use and branch-compare hazards combinationally. Owns a sequential multi-cycle divide tracker (IDLE/BUSY/DONE FSM) that launches the external divider and freezes the pipeline until it completes.

---
 rtl/hazard_ctrl_if.sv | 31 +++
 rtl/hazard_ctrl.sv | 118 +++++++++++
 tb/tb_hazard_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Handshake bundle between the pipeline (master) and the hazard/stall generator (slave).
interface hazard_ctrl_if;
  logic [4:0] rsD, rtD, rsE, rtE;
  logic [4:0] writeregE, writeregM, writeregW;
  logic       regwriteE, regwriteM, regwriteW;
  logic       memtoregE, memtoregM;
  logic       branchD, jrD;
  logic       divE, signed_divE, div_ready;
  logic       div_start, div_signed, div_busy, div_err;
  logic       stallF, stallD, stallE, stallM, stallW, flushE;
  logic       forwardaD, forwardbD;
  logic [1:0] forwardaE, forwardbE;

  modport slave (
    input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
    input  regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
    input  branchD, jrD, divE, signed_divE, div_ready,
    output div_start, div_signed, div_busy, div_err,
    output stallF, stallD, stallE, stallM, stallW, flushE,
    output forwardaD, forwardbD, forwardaE, forwardbE
  );

  modport master (
    output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
    output regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
    output branchD, jrD, divE, signed_divE, div_ready,
    input  div_start, div_signed, div_busy, div_err,
    input  stallF, stallD, stallE, stallM, stallW, flushE,
    input  forwardaD, forwardbD, forwardaE, forwardbE
  );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage MIPS hazard unit: forwarding, load-use/branch stalls and a multi-cycle divide tracker.
// Optional divide watchdog enabled by defining DIV_TIMEOUT_EN.
module hazard_ctrl #(
  parameter int unsigned DIV_MAX_CYCLES = 40,
  parameter int unsigned CNT_W          = 6
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave hif
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} divState_t;

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DIV_MAX_CYCLES);
`ifdef DIV_TIMEOUT_EN
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DIV_MAX_CYCLES - 1);
`endif

  divState_t        stateQ, stateD;
  logic [CNT_W-1:0] cntQ, cntD;
  logic             errQ, errD;
  logic             lwStall, brStall, hzStall, brUse;

  assign lwStall = hif.memtoregE & ((hif.rtE == hif.rsD) | (hif.rtE == hif.rtD));
  assign brUse   = hif.branchD | hif.jrD;
  assign brStall = (brUse & hif.regwriteE & (hif.writeregE != 5'd0) &
                    ((hif.writeregE == hif.rsD) | (hif.branchD & (hif.writeregE == hif.rtD)))) |
                   (brUse & hif.memtoregM & (hif.writeregM != 5'd0) &
                    ((hif.writeregM == hif.rsD) | (hif.branchD & (hif.writeregM == hif.rtD))));
  assign hzStall = lwStall | brStall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ <= StIdle;
      cntQ   <= '0;
      errQ   <= 1'b0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
      errQ   <= errD;
    end
  end

  // Every output is held low while reset is asserted, including the combinational paths.
  always_comb begin
    stateD         = stateQ;
    cntD           = cntQ;
    errD           = errQ;
    hif.div_start  = 1'b0;
    hif.div_signed = 1'b0;
    hif.div_busy   = 1'b0;
    hif.stallF     = 1'b0;
    hif.stallD     = 1'b0;
    hif.stallE     = 1'b0;
    hif.stallM     = 1'b0;
    hif.stallW     = 1'b0;
    hif.flushE     = 1'b0;
    hif.forwardaD  = 1'b0;
    hif.forwardbD  = 1'b0;
    hif.forwardaE  = 2'b00;
    hif.forwardbE  = 2'b00;
    if (rst) begin
      if ((hif.rsE != 5'd0) && hif.regwriteM && (hif.rsE == hif.writeregM)) begin
        hif.forwardaE = 2'b10;
      end else if ((hif.rsE != 5'd0) && hif.regwriteW && (hif.rsE == hif.writeregW)) begin
        hif.forwardaE = 2'b01;
      end
      if ((hif.rtE != 5'd0) && hif.regwriteM && (hif.rtE == hif.writeregM)) begin
        hif.forwardbE = 2'b10;
      end else if ((hif.rtE != 5'd0) && hif.regwriteW && (hif.rtE == hif.writeregW)) begin
        hif.forwardbE = 2'b01;
      end
      hif.forwardaD = (hif.rsD != 5'd0) & hif.regwriteM & (hif.rsD == hif.writeregM);
      hif.forwardbD = (hif.rtD != 5'd0) & hif.regwriteM & (hif.rtD == hif.writeregM);

      unique case (stateQ)
        StIdle: begin
          cntD = '0;
          if (hif.divE) begin
            // Launch wins over hazards: freeze everything, no bubble.
            hif.div_start  = 1'b1;
            hif.div_signed = hif.signed_divE;
            {hif.stallF, hif.stallD, hif.stallE, hif.stallM, hif.stallW} = 5'b11111;
            stateD         = StBusy;
          end else begin
            {hif.stallF, hif.stallD, hif.flushE} = {3{hzStall}};
          end
        end
        StBusy: begin
          {hif.stallF, hif.stallD, hif.stallE, hif.stallM, hif.stallW} = 5'b11111;
          hif.div_busy = 1'b1;
          if (cntQ != CntMax) cntD = cntQ + 1'b1;
          if (hif.div_ready) begin
            stateD = StDone;
`ifdef DIV_TIMEOUT_EN
          end else if (cntQ == CntLast) begin
            stateD = StDone;
            errD   = 1'b1;
`endif
          end
        end
        StDone: begin
          // Divide leaves E on this edge; divE still high here must not relaunch.
          {hif.stallF, hif.stallD, hif.flushE} = {3{hzStall}};
          stateD = StIdle;
        end
        default: stateD = StIdle;
      endcase
    end
  end

`ifdef DIV_TIMEOUT_EN
  assign hif.div_err = errQ;
`else
  assign hif.div_err = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (watchdog checks follow DIV_TIMEOUT_EN).
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   passCnt  = 0;
  int   totalCnt = 0;
  int   failCnt  = 0;

  hazard_ctrl_if hif ();

  hazard_ctrl #(
    .DIV_MAX_CYCLES(40),
    .CNT_W         (6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hif(hif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {stallF, stallD, stallE, stallM, stallW, flushE}
  function automatic logic [7:0] stalls();
    return {2'b00, hif.stallF, hif.stallD, hif.stallE, hif.stallM, hif.stallW, hif.flushE};
  endfunction

  task automatic clearIn();
    {hif.rsD, hif.rtD, hif.rsE, hif.rtE} = '0;
    {hif.writeregE, hif.writeregM, hif.writeregW} = '0;
    {hif.regwriteE, hif.regwriteM, hif.regwriteW, hif.memtoregE, hif.memtoregM} = '0;
    {hif.branchD, hif.jrD, hif.divE, hif.signed_divE, hif.div_ready} = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clearIn();
    // Reset with hazard-producing inputs: outputs must still be 0.
    hif.memtoregE = 1'b1; hif.rtE = 5'd8; hif.rsD = 5'd8; hif.divE = 1'b1;
    hif.regwriteM = 1'b1; hif.writeregM = 5'd8; hif.rsE = 5'd8;
    #12;
    chk("reset_stalls", stalls(), 8'h00);
    chk("reset_fwdE", {4'h0, hif.forwardaE, hif.forwardbE}, 8'h00);
    chk("reset_misc", {4'h0, hif.div_start, hif.div_busy, hif.div_err, hif.forwardaD}, 8'h00);
    clearIn();
    #3 rst = 1'b1;
    tick();

    // Load-use
    hif.memtoregE = 1'b1; hif.rtE = 5'd8; hif.rsD = 5'd8; #1;
    chk("lw_stall", stalls(), 8'b0011_0001);
    tick();
    hif.memtoregE = 1'b0; #1;
    chk("lw_clear", stalls(), 8'h00);
    clearIn(); #1;

    // Forwarding
    hif.regwriteM = 1'b1; hif.writeregM = 5'd5; hif.regwriteW = 1'b1; hif.writeregW = 5'd5;
    hif.rsE = 5'd5; #1;
    chk("fwdA_M_over_W", {6'h0, hif.forwardaE}, 8'h02);
    hif.regwriteM = 1'b0; #1;
    chk("fwdA_W", {6'h0, hif.forwardaE}, 8'h01);
    hif.regwriteM = 1'b1; hif.writeregM = 5'd0; hif.writeregW = 5'd0; hif.rsE = 5'd0; #1;
    chk("fwdA_zero", {6'h0, hif.forwardaE}, 8'h00);
    hif.rtE = 5'd7; hif.writeregW = 5'd7; #1;
    chk("fwdB_W", {6'h0, hif.forwardbE}, 8'h01);
    hif.writeregM = 5'd4; hif.rsD = 5'd4; hif.rtD = 5'd4; #1;
    chk("fwdD_both", {6'h0, hif.forwardaD, hif.forwardbD}, 8'h03);
    hif.regwriteM = 1'b0; #1;
    chk("fwdD_none", {6'h0, hif.forwardaD, hif.forwardbD}, 8'h00);
    clearIn(); #1;

    // Branch compare hazards
    hif.branchD = 1'b1; hif.rsD = 5'd3; hif.regwriteE = 1'b1; hif.writeregE = 5'd3; #1;
    chk("br_E_rs", stalls(), 8'b0011_0001);
    hif.branchD = 1'b0; hif.jrD = 1'b1; hif.rsD = 5'd1; hif.rtD = 5'd3; #1;
    chk("jr_rt_only", stalls(), 8'h00);
    clearIn();
    hif.branchD = 1'b1; hif.rtD = 5'd6; hif.rsD = 5'd2; hif.memtoregM = 1'b1;
    hif.writeregM = 5'd6; #1;
    chk("br_M_load_rt", stalls(), 8'b0011_0001);
    hif.writeregM = 5'd0; hif.rtD = 5'd0; #1;
    chk("br_M_zero", stalls(), 8'h00);
    clearIn(); #1;

    // Divide launch with a concurrent load-use hazard
    hif.divE = 1'b1; hif.signed_divE = 1'b1;
    hif.memtoregE = 1'b1; hif.rtE = 5'd9; hif.rsD = 5'd9; #1;
    chk("div_launch_stalls", stalls(), 8'b0011_1110);
    chk("div_launch_start", {6'h0, hif.div_start, hif.div_signed}, 8'h03);
    tick();
    hif.memtoregE = 1'b0; #1;
    chk("div_busy", {6'h0, hif.div_start, hif.div_busy}, 8'h01);
    chk("div_busy_stalls", stalls(), 8'b0011_1110);
    for (int i = 0; i < 32; i++) tick();
    hif.div_ready = 1'b1; #1;
    chk("div_still_busy", {7'h0, hif.div_busy}, 8'h01);
    tick();
    hif.div_ready = 1'b0; #1;
    chk("div_done_stalls", stalls(), 8'h00);
    chk("div_done_nostart", {6'h0, hif.div_start, hif.div_busy}, 8'h00);
    tick();
    chk("div_b2b_start", {7'h0, hif.div_start}, 8'h01);
    tick();
    hif.signed_divE = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("div2_busy", {7'h0, hif.div_busy}, 8'h01);
    rst = 1'b0; #1;
    chk("rst_mid_busy", stalls(), 8'h00);
    chk("rst_mid_busy_flags", {6'h0, hif.div_start, hif.div_busy}, 8'h00);
    hif.divE = 1'b0; hif.div_ready = 1'b1;
    #2 rst = 1'b1;
    tick();
    chk("ready_in_idle", {7'h0, hif.div_busy}, 8'h00);
    hif.div_ready = 1'b0; hif.divE = 1'b1; #1;
    chk("relaunch", {6'h0, hif.div_start, hif.div_signed}, 8'h02);
    tick();
    chk("relaunch_busy", {7'h0, hif.div_busy}, 8'h01);

    // Watchdog: BUSY is entered on the previous edge, counter starts at 0.
    for (int i = 0; i < 39; i++) tick();
    chk("wd_busy_39", {6'h0, hif.div_busy, hif.div_err}, 8'h02);
    tick();
`ifdef DIV_TIMEOUT_EN
    chk("wd_done", {6'h0, hif.div_busy, hif.div_err}, 8'h01);
    chk("wd_done_stalls", stalls(), 8'h00);
    hif.divE = 1'b0;
    tick();
    chk("wd_sticky", {6'h0, hif.div_busy, hif.div_err}, 8'h01);
    rst = 1'b0; #1;
    chk("wd_cleared", {7'h0, hif.div_err}, 8'h00);
    #2 rst = 1'b1;
`else
    for (int i = 0; i < 20; i++) tick();
    chk("nowd_busy", {6'h0, hif.div_busy, hif.div_err}, 8'h02);
    hif.div_ready = 1'b1;
    tick();
    hif.div_ready = 1'b0; #1;
    chk("nowd_done", {6'h0, hif.div_busy, hif.div_err}, 8'h00);
    hif.divE = 1'b0;
    tick();
    chk("nowd_idle", stalls(), 8'h00);
`endif

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
